// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
// Shares the internal register bus between two requesters (A = SPI command
// path, B = on-chip sequencer). Each grant runs a fixed 4-cycle transaction
// IDLE -> ACCESS -> WAIT -> DONE. Contention is resolved round-robin on a
// last-served pointer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus quiet, arbitrate and latch the winning request
// ACCESS | address/data on bus, write strobe if latched wr is set
// WAIT   | address held, read data captured at the end of the cycle
// DONE   | owner ack pulse, last-served pointer updated

module reg_bus_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_req,
    input  logic                  i_a_wr,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_ack,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_req,
    input  logic                  i_b_wr,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_ack,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic [ADDR_WIDTH-1:0] o_addr_bus,
    output logic [DATA_WIDTH-1:0] o_data_write_bus,
    output logic                  o_wr_enable_bus,
    input  logic [DATA_WIDTH-1:0] i_data_read_bus,
    output logic                  o_busy,
    output logic                  o_owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  grant;
    logic                  grant_b;
    logic                  last_b;
    logic                  lat_owner;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [DATA_WIDTH-1:0] b_rdata;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant decision; B wins only if A is absent or A was served last
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_b    = 1'b0;
        case (state)
            IDLE: begin
                if (i_a_req || i_b_req) begin
                    grant      = 1'b1;
                    grant_b    = i_b_req && (!i_a_req || !last_b);
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = WAIT;
            WAIT:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latch the winning request at grant; pointer resets to "B served last" so A wins first
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_b    <= 1'b1;
            lat_owner <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            if (grant) begin
                lat_owner <= grant_b;
                lat_wr    <= grant_b ? i_b_wr    : i_a_wr;
                lat_addr  <= grant_b ? i_b_addr  : i_a_addr;
                lat_wdata <= grant_b ? i_b_wdata : i_a_wdata;
            end
            if (state == DONE) begin
                last_b <= lat_owner;
            end
        end
    end

    // Capture read data into the owner's register at the end of WAIT; writes leave it alone
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (state == WAIT && !lat_wr) begin
            if (lat_owner) begin
                b_rdata <= i_data_read_bus;
            end else begin
                a_rdata <= i_data_read_bus;
            end
        end
    end

    // Bus outputs come straight from the latches so they hold their value through IDLE
    assign o_addr_bus       = lat_addr;
    assign o_data_write_bus = lat_wdata;
    assign o_owner          = lat_owner;
    assign o_wr_enable_bus  = (state == ACCESS) && lat_wr;
    assign o_busy           = (state != IDLE);
    assign o_a_ack          = (state == DONE) && !lat_owner;
    assign o_b_ack          = (state == DONE) && lat_owner;
    assign o_a_rdata        = a_rdata;
    assign o_b_rdata        = b_rdata;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with a simple register-map model whose
// read data is registered (valid the cycle after the address is presented).

module tb_reg_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req;
    logic       a_wr;
    logic [6:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req;
    logic       b_wr;
    logic [6:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic [6:0] addr_bus;
    logic [7:0] data_write_bus;
    logic       wr_enable_bus;
    logic [7:0] data_read_bus;
    logic       busy;
    logic       owner;

    logic [7:0] reg_map [128];

    int num_checks;
    int num_errors;

    reg_bus_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_a_req          (a_req),
        .i_a_wr           (a_wr),
        .i_a_addr         (a_addr),
        .i_a_wdata        (a_wdata),
        .o_a_ack          (a_ack),
        .o_a_rdata        (a_rdata),
        .i_b_req          (b_req),
        .i_b_wr           (b_wr),
        .i_b_addr         (b_addr),
        .i_b_wdata        (b_wdata),
        .o_b_ack          (b_ack),
        .o_b_rdata        (b_rdata),
        .o_addr_bus       (addr_bus),
        .o_data_write_bus (data_write_bus),
        .o_wr_enable_bus  (wr_enable_bus),
        .i_data_read_bus  (data_read_bus),
        .o_busy           (busy),
        .o_owner          (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register map model: registered read, write on strobe
    always @(posedge clk) begin
        if (wr_enable_bus) reg_map[addr_bus] <= data_write_bus;
        data_read_bus <= reg_map[addr_bus];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " a_ack"},   a_ack, 0);
        check_val({tag, " b_ack"},   b_ack, 0);
        check_val({tag, " a_rdata"}, a_rdata, 0);
        check_val({tag, " b_rdata"}, b_rdata, 0);
        check_val({tag, " addr"},    addr_bus, 0);
        check_val({tag, " wdata"},   data_write_bus, 0);
        check_val({tag, " wr_en"},   wr_enable_bus, 0);
        check_val({tag, " busy"},    busy, 0);
        check_val({tag, " owner"},   owner, 0);
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        for (int i = 0; i < 128; i++) reg_map[i] = 8'h00;
        reg_map[7'h01] = 8'h11;
        reg_map[7'h02] = 8'h22;
        reg_map[7'h10] = 8'h3C;
        data_read_bus = 8'h00;
        rst = 1'b0;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;

        // A write 0xA5 to 0x05
        a_req = 1; a_wr = 1; a_addr = 7'h05; a_wdata = 8'hA5;
        tick();
        check_val("wrA c1 wr_en", wr_enable_bus, 1);
        check_val("wrA c1 addr",  addr_bus, 7'h05);
        check_val("wrA c1 data",  data_write_bus, 8'hA5);
        check_val("wrA c1 busy",  busy, 1);
        check_val("wrA c1 owner", owner, 0);
        a_req = 0;
        tick();
        check_val("wrA c2 wr_en", wr_enable_bus, 0);
        check_val("wrA c2 addr",  addr_bus, 7'h05);
        check_val("wrA c2 ack",   a_ack, 0);
        tick();
        check_val("wrA c3 ack",   a_ack, 1);
        check_val("wrA c3 rdata", a_rdata, 8'h00);
        check_val("wrA c3 b_ack", b_ack, 0);
        check_val("wrA c3 wr_en", wr_enable_bus, 0);
        tick();
        check_val("wrA c4 ack",   a_ack, 0);
        check_val("wrA c4 busy",  busy, 0);
        check_val("wrA c4 addr hold", addr_bus, 7'h05);
        check_val("wrA map",      reg_map[7'h05], 8'hA5);

        // B read of 0x10
        b_req = 1; b_wr = 0; b_addr = 7'h10;
        tick();
        check_val("rdB c1 addr",  addr_bus, 7'h10);
        check_val("rdB c1 wr_en", wr_enable_bus, 0);
        check_val("rdB c1 owner", owner, 1);
        b_req = 0;
        tick();
        check_val("rdB c2 addr",  addr_bus, 7'h10);
        check_val("rdB c2 wr_en", wr_enable_bus, 0);
        tick();
        check_val("rdB c3 ack",   b_ack, 1);
        check_val("rdB c3 rdata", b_rdata, 8'h3C);
        check_val("rdB c3 a_ack", a_ack, 0);
        check_val("rdB c3 a_rdata", a_rdata, 8'h00);
        tick();
        check_val("rdB c4 ack",   b_ack, 0);
        check_val("rdB c4 owner hold", owner, 1);

        // Contention from reset: A, B, A, B
        rst = 1'b0;
        a_req = 1; a_wr = 0; a_addr = 7'h01;
        b_req = 1; b_wr = 0; b_addr = 7'h02;
        tick();
        rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check_val($sformatf("cont c%0d a_ack", c), a_ack, (c == 3 || c == 11) ? 1 : 0);
            check_val($sformatf("cont c%0d b_ack", c), b_ack, (c == 7 || c == 15) ? 1 : 0);
            if (c == 1 || c == 9) check_val($sformatf("cont c%0d owner", c), owner, 0);
            if (c == 5 || c == 13) check_val($sformatf("cont c%0d owner", c), owner, 1);
            if (c == 4 || c == 8) check_val($sformatf("cont c%0d busy", c), busy, 0);
        end
        check_val("cont a_rdata", a_rdata, 8'h11);
        check_val("cont b_rdata", b_rdata, 8'h22);
        a_req = 0; b_req = 0;
        tick();
        check_val("cont idle busy", busy, 0);

        // Mid-transaction change of A request is ignored
        a_req = 1; a_wr = 0; a_addr = 7'h02;
        tick();
        check_val("mid c1 addr", addr_bus, 7'h02);
        a_req = 0; a_addr = 7'h7F; a_wr = 1; a_wdata = 8'hFF;
        tick();
        check_val("mid c2 addr",  addr_bus, 7'h02);
        check_val("mid c2 wr_en", wr_enable_bus, 0);
        tick();
        check_val("mid c3 ack",   a_ack, 1);
        check_val("mid c3 rdata", a_rdata, 8'h22);
        tick();
        check_val("mid c4 map7F", reg_map[7'h7F], 8'h00);

        // Reset during WAIT, then pending B granted
        a_req = 1; a_wr = 0; a_addr = 7'h01;
        tick();
        a_req = 0;
        b_req = 1; b_wr = 0; b_addr = 7'h10;
        tick();
        check_val("rstmid in WAIT busy", busy, 1);
        rst = 1'b0;
        #1;
        check_all_zero("rstmid async");
        tick();
        check_val("rstmid no ack", a_ack, 0);
        rst = 1'b1;
        tick();
        check_val("rstmid B c1 owner", owner, 1);
        check_val("rstmid B c1 busy",  busy, 1);
        check_val("rstmid B c1 addr",  addr_bus, 7'h10);
        b_req = 0;
        tick();
        tick();
        check_val("rstmid B c3 ack",   b_ack, 1);
        check_val("rstmid B c3 rdata", b_rdata, 8'h3C);
        check_val("rstmid A no ack",   a_ack, 0);
        tick();

        // Write then read-back, then a write that must not disturb a_rdata
        a_req = 1; a_wr = 1; a_addr = 7'h08; a_wdata = 8'h5A;
        tick();
        check_val("wb wr c1 wr_en", wr_enable_bus, 1);
        a_req = 0;
        tick();
        tick();
        check_val("wb wr c3 ack",   a_ack, 1);
        check_val("wb wr c3 rdata", a_rdata, 8'h00);
        tick();
        a_req = 1; a_wr = 0; a_addr = 7'h08;
        tick();
        a_req = 0;
        tick();
        tick();
        check_val("wb rd c3 ack",   a_ack, 1);
        check_val("wb rd c3 rdata", a_rdata, 8'h5A);
        tick();
        a_req = 1; a_wr = 1; a_addr = 7'h09; a_wdata = 8'h33;
        tick();
        a_req = 0;
        tick();
        tick();
        check_val("wb wr2 c3 ack",   a_ack, 1);
        check_val("wb wr2 c3 rdata", a_rdata, 8'h5A);
        check_val("wb wr2 map",      reg_map[7'h09], 8'h33);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
